// File: rtl/udp_tx_sched_pkg.sv
// Shared constants, FSM encoding and length helper for the UDP transmit scheduler.
package udp_tx_sched_pkg;

  localparam logic [15:0] IP_HDR_LEN      = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN     = 16'd8;
  localparam logic [15:0] DEF_MAX_PAYLOAD = 16'd1472;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_TRIG       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_END   = 3'd4,
    ST_GAP        = 3'd5
  } state_t;

  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] cap);
    if (len > cap) begin
      return cap;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/udp_tx_sched_if.sv
// Requester and transmit-engine bundle seen by the scheduler (master) and its environment (slave).
interface udp_tx_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_len;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic                send_trigger;
  logic [15:0]         tx_data_length;
  logic [15:0]         tx_total_length;
  logic [10:0]         ram_base;
  logic                e_txen;
  logic                busy;

  modport master (
    input  req, req_len, e_txen,
    output grant, done, err, send_trigger, tx_data_length, tx_total_length, ram_base, busy
  );

  modport slave (
    output req, req_len, e_txen,
    input  grant, done, err, send_trigger, tx_data_length, tx_total_length, ram_base, busy
  );
endinterface

// File: rtl/udp_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping at N_REQ.
module udp_tx_sched_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic hit_s;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s + 0;
    end
    return IDX_W'(s);
  endfunction

  // Scan from farthest to nearest so the candidate closest to ptr overwrites the rest.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    hit_s = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      hit_s = req[wrap_add(ptr, i)];
      idx   = hit_s ? wrap_add(ptr, i) : idx;
      valid = valid | hit_s;
    end
    gnt[idx] = valid;
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Round-robin owner of the single UDP/IP transmit engine: arbitration, length/base latching,
// start timeout, inter-frame gap and done/err reporting back to the requesters.
module udp_tx_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int BUF_WORDS   = 128,
  parameter int IFG_CYCLES  = 12,
  parameter int START_TO    = 64,
  parameter int MAX_PAYLOAD = int'(DEF_MAX_PAYLOAD)
) (
  input logic            e_rxc,
  input logic            reset,
  udp_tx_sched_if.master bus
);

  localparam int          IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] LEN_CAP    = 16'(MAX_PAYLOAD);
  localparam logic [7:0]  START_LAST = 8'(START_TO - 1);
  localparam logic [7:0]  IFG_LAST   = 8'(IFG_CYCLES - 1);

  state_t           state_r, state_nx;
  logic [IDX_W-1:0] ptr_r;
  logic [7:0]       cnt_r;

  logic [N_REQ-1:0] win_gnt_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_valid_s;
  logic [15:0]      win_raw_s;
  logic [15:0]      win_len_s;
  logic             load_s;

  logic [N_REQ-1:0] grant_r, done_r, err_r;
  logic [N_REQ-1:0] grant_nx, done_nx, err_nx;
  logic             trig_r, trig_nx, busy_r;
  logic [15:0]      data_len_r, total_len_r;
  logic [10:0]      base_r;

  udp_tx_sched_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_r),
    .gnt   (win_gnt_s),
    .idx   (win_idx_s),
    .valid (win_valid_s)
  );

  // Mux the winner's requested length out of the packed bus and clamp it.
  always_comb begin
    win_raw_s = 16'd0;
    for (int i = 0; i < N_REQ; i++) begin
      win_raw_s = win_raw_s | (bus.req_len[16*i +: 16] & {16{win_gnt_s[i]}});
    end
    win_len_s = clamp_len(win_raw_s, LEN_CAP);
  end

  // State, round-robin pointer and the shared timeout/gap counter.
  always_ff @(posedge e_rxc or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nx;
      if (load_s) begin
        ptr_r <= (win_idx_s == IDX_W'(N_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
      end
      if (state_nx != state_r) begin
        cnt_r <= 8'd0;
      end else if (state_r == ST_WAIT_START || state_r == ST_GAP) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Next-state decode; IDLE also waits out a frame still on the wire after reset.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((|bus.req) && !bus.e_txen) begin
          state_nx = ST_ARB;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (win_valid_s && (win_len_s != 16'd0)) begin
          state_nx = ST_TRIG;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_TRIG: state_nx = ST_WAIT_START;
      ST_WAIT_START: begin
        if (bus.e_txen) begin
          state_nx = ST_WAIT_END;
        end else if (cnt_r == START_LAST) begin
          state_nx = ST_GAP;
        end else begin
          state_nx = ST_WAIT_START;
        end
      end
      ST_WAIT_END: begin
        if (!bus.e_txen) begin
          state_nx = ST_GAP;
        end else begin
          state_nx = ST_WAIT_END;
        end
      end
      ST_GAP: begin
        if (cnt_r == IFG_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_GAP;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode: next values of grant and the single-cycle pulses.
  always_comb begin
    grant_nx = grant_r;
    done_nx  = '0;
    err_nx   = '0;
    trig_nx  = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      ST_ARB: begin
        load_s = win_valid_s;
        if (win_valid_s && (win_len_s == 16'd0)) begin
          err_nx   = win_gnt_s;
          grant_nx = '0;
        end else begin
          grant_nx = win_gnt_s;
        end
      end
      ST_TRIG: trig_nx = 1'b1;
      ST_WAIT_START: begin
        if (!bus.e_txen && (cnt_r == START_LAST)) begin
          err_nx   = grant_r;
          grant_nx = '0;
        end else begin
          grant_nx = grant_r;
        end
      end
      ST_WAIT_END: begin
        if (!bus.e_txen) begin
          done_nx  = grant_r;
          grant_nx = '0;
        end else begin
          grant_nx = grant_r;
        end
      end
      ST_IDLE, ST_GAP: grant_nx = '0;
      default:         grant_nx = '0;
    endcase
  end

  // Registered outputs; frame parameters only change on an ARB exit.
  always_ff @(posedge e_rxc or posedge reset) begin
    if (reset) begin
      grant_r     <= '0;
      done_r      <= '0;
      err_r       <= '0;
      trig_r      <= 1'b0;
      busy_r      <= 1'b0;
      data_len_r  <= 16'd0;
      total_len_r <= 16'd0;
      base_r      <= 11'd0;
    end else begin
      grant_r <= grant_nx;
      done_r  <= done_nx;
      err_r   <= err_nx;
      trig_r  <= trig_nx;
      busy_r  <= (state_nx != ST_IDLE);
      if (load_s) begin
        data_len_r  <= win_len_s + UDP_HDR_LEN;
        total_len_r <= win_len_s + UDP_HDR_LEN + IP_HDR_LEN;
        base_r      <= 11'(int'(win_idx_s) * BUF_WORDS);
      end
    end
  end

  assign bus.grant           = grant_r;
  assign bus.done            = done_r;
  assign bus.err             = err_r;
  assign bus.send_trigger    = trig_r;
  assign bus.busy            = busy_r;
  assign bus.tx_data_length  = data_len_r;
  assign bus.tx_total_length = total_len_r;
  assign bus.ram_base        = base_r;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed and randomized bench for udp_tx_sched with a frame-level reference model.
module tb_udp_tx_sched;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int trig_seen = 0;
  int done_seen = 0;
  int exp_trig = 0;
  int exp_done = 0;
  int mptr = 0;
  int last_trig_cyc = 0;
  int last_fall_cyc = 0;
  int fall0 = 0;
  logic [15:0]  lens [N];
  logic [N-1:0] cur_req;

  udp_tx_sched_if #(.N_REQ(N)) bus ();

  udp_tx_sched #(
    .N_REQ       (N),
    .BUF_WORDS   (128),
    .IFG_CYCLES  (12),
    .START_TO    (64),
    .MAX_PAYLOAD (1472)
  ) dut (
    .e_rxc (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #4 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.send_trigger === 1'b1) trig_seen <= trig_seen + 1;
    if (bus.done !== '0) done_seen <= done_seen + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [N-1:0] r);
    cur_req = r;
    bus.req = r;
    for (int i = 0; i < N; i++) bus.req_len[16*i +: 16] = lens[i];
  endtask

  // Reference: first pending requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (((int'(r) >> ((p + k) % N)) & 1) == 1) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int clampv(input int l);
    return (l > 1472) ? 1472 : l;
  endfunction

  task automatic wait_trig(input string tag);
    int k;
    k = 0;
    while (bus.send_trigger !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_trig"}, 32'(bus.send_trigger), 32'd1);
    last_trig_cyc = cyc;
  endtask

  // One arbitration round as seen from outside: reject, timeout or a completed frame.
  task automatic do_frame(input string tag, input logic [N-1:0] arb_req,
                          input int dly, input int hi, input bit tmo);
    int w, l, k;
    logic [N-1:0] oh;
    w = pick(arb_req, mptr);
    if (w >= 0) begin
      mptr = (w + 1) % N;
      l = clampv(int'(lens[w]));
      oh = 4'b0001 << w;
      if (l == 0) begin
        k = 0;
        while (bus.err === '0 && k < 20) begin
          tick();
          k++;
        end
        chk({tag, "_err0"}, 32'(bus.err), 32'(oh));
        chk({tag, "_err0_grant"}, 32'(bus.grant), 32'd0);
        chk({tag, "_err0_notrig"}, 32'(bus.send_trigger), 32'd0);
        chk({tag, "_err0_busy"}, 32'(bus.busy), 32'd0);
      end else begin
        wait_trig(tag);
        exp_trig++;
        chk({tag, "_grant"}, 32'(bus.grant), 32'(oh));
        chk({tag, "_dlen"}, 32'(bus.tx_data_length), 32'(l + 8));
        chk({tag, "_tlen"}, 32'(bus.tx_total_length), 32'(l + 28));
        chk({tag, "_base"}, 32'(bus.ram_base), 32'(w * 128));
        if (tmo) begin
          repeat (63) tick();
          chk({tag, "_to_early"}, 32'(bus.err), 32'd0);
          tick();
          chk({tag, "_to_err"}, 32'(bus.err), 32'(oh));
          chk({tag, "_to_grant"}, 32'(bus.grant), 32'd0);
          chk({tag, "_to_nodone"}, 32'(bus.done), 32'd0);
        end else begin
          repeat (dly) tick();
          bus.e_txen = 1'b1;
          repeat (hi) tick();
          chk({tag, "_dlen_hold"}, 32'(bus.tx_data_length), 32'(l + 8));
          chk({tag, "_grant_hold"}, 32'(bus.grant), 32'(oh));
          bus.e_txen = 1'b0;
          last_fall_cyc = cyc;
          tick();
          chk({tag, "_done"}, 32'(bus.done), 32'(oh));
          chk({tag, "_done_grant"}, 32'(bus.grant), 32'd0);
          exp_done++;
        end
        tick();
        chk({tag, "_pulse_end"}, 32'({bus.done, bus.err}), 32'd0);
        repeat (10) tick();
        chk({tag, "_gap_busy"}, 32'(bus.busy), 32'd1);
        tick();
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_len = '0;
    bus.e_txen = 1'b0;
    cur_req = '0;
    for (int i = 0; i < N; i++) lens[i] = 16'd0;
    repeat (3) tick();
    chk("rst_outs", 32'({bus.grant, bus.done, bus.err, bus.send_trigger, bus.busy}), 32'd0);
    chk("rst_lens", {bus.tx_data_length, bus.tx_total_length}, 32'd0);
    chk("rst_base", 32'(bus.ram_base), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_noreq", 32'(bus.busy), 32'd0);

    // Single frame with request dropped while granted.
    lens[1] = 16'd100;
    set_req(4'b0010);
    tick();
    chk("lat_arb", 32'(bus.grant), 32'd0);
    tick();
    chk("lat_grant", 32'(bus.grant), 32'h2);
    chk("lat_notrig", 32'(bus.send_trigger), 32'd0);
    set_req(4'b0000);
    tick();
    chk("lat_trig", 32'(bus.send_trigger), 32'd1);
    do_frame("single", 4'b0010, 5, 150, 1'b0);

    // Fairness from pointer 0 with all four requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = 0;
    for (int i = 0; i < N; i++) lens[i] = 16'($urandom_range(1, 1472));
    set_req(4'b1111);
    for (int f = 0; f < 5; f++) do_frame("fair", cur_req, $urandom_range(0, 8), $urandom_range(1, 20), 1'b0);

    // Zero length rejection, then oversize clamp.
    lens[0] = 16'd0;
    set_req(4'b0001);
    do_frame("len0", cur_req, 0, 1, 1'b0);
    lens[3] = 16'd2000;
    set_req(4'b1000);
    do_frame("clamp", cur_req, 2, 10, 1'b0);

    // Start timeout.
    lens[2] = 16'd64;
    set_req(4'b0100);
    do_frame("tmo", cur_req, 0, 1, 1'b1);

    // Second request pending when the first frame ends.
    lens[0] = 16'd200;
    lens[1] = 16'd300;
    set_req(4'b0011);
    do_frame("ifg_a", cur_req, 1, 20, 1'b0);
    fall0 = last_fall_cyc;
    do_frame("ifg_b", cur_req, 1, 20, 1'b0);
    chk("ifg_ge14", 32'((last_trig_cyc - fall0) >= 14), 32'd1);

    // Reset in the middle of a frame while the engine keeps transmitting.
    lens[2] = 16'd300;
    set_req(4'b0100);
    wait_trig("rst_mid");
    exp_trig++;
    repeat (3) tick();
    bus.e_txen = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({bus.grant, bus.done, bus.err, bus.send_trigger, bus.busy}), 32'd0);
    chk("rst_mid_len", 32'(bus.tx_data_length), 32'd0);
    chk("rst_mid_base", 32'(bus.ram_base), 32'd0);
    tick();
    rst = 1'b0;
    mptr = 0;
    repeat (6) tick();
    chk("rst_hold_busy", 32'(bus.busy), 32'd0);
    chk("rst_hold_grant", 32'(bus.grant), 32'd0);
    bus.e_txen = 1'b0;
    do_frame("rst_resume", cur_req, 3, 12, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 24; it++) begin
      int cat;
      for (int i = 0; i < N; i++) begin
        cat = $urandom_range(0, 9);
        if (cat == 0) lens[i] = 16'd0;
        else if (cat == 1) lens[i] = 16'($urandom_range(1473, 3000));
        else lens[i] = 16'($urandom_range(1, 1472));
      end
      set_req(4'($urandom_range(1, 15)));
      do_frame("rand", cur_req, $urandom_range(0, 20), $urandom_range(1, 30),
               ($urandom_range(0, 7) == 0));
    end

    set_req(4'b0000);
    repeat (20) tick();
    chk("final_idle", 32'(bus.busy), 32'd0);
    chk("trig_count", 32'(trig_seen), 32'(exp_trig));
    chk("done_count", 32'(done_seen), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
